wd_reset_sequencer: RTL and testbench
=====================================

# wd_reset_sequencer

Frame-rate reset sequencer that sits directly downstream of the watchdog kick decode. It counts WDCLK ticks since the last kick. On timeout it drives the system reset lines through a staged hold/release sequence: YM first, then Z80, then 68k/HALT. The kick strobe is its asynchronous reset, so any write to $300001 instantly returns it to the running state.

## Interface
Parameters:
- TIMEOUT, 8: WDCLK rising edges without a kick before the bite; ≥2.
- HOLD_LEN, 8: edges during which all resets stay asserted; ≥1.
- REL_LAG, 2: edges between successive staged releases; ≥1.
- WARN_LEAD, 2: edges before the bite at which WD_WARN rises; <TIMEOUT.

Ports:
- WDCLK  in  1  frame-rate clock, rising edge.
- WDRESET  in  1  reset, asynchronous, active-high; this is the watchdog kick strobe.
- nRST  in  1  system power-on/button reset, active-low.
- nRESET  out  1  68k reset, active-low.
- nHALT  out  1  68k halt, active-low; identical to nRESET.
- nZ80RST  out  1  Z80 reset, active-low.
- nYMRST  out  1  YM2610 reset, active-low.
- WD_BITE  out  1  one-WDCLK-period pulse marking the timeout edge.
- WD_WARN  out  1  high during the last WARN_LEAD ticks of RUN.
- WD_STATE  out  2  state code: 0 RUN, 1 HOLD, 2 REL_YM, 3 REL_Z80.

## Operation
- State register is one-hot: RUN, HOLD, REL_YM, REL_Z80. Each output is a single flop output ANDed with nRST, so there is no decode glitch.
- RUN:
  - cnt increments on every edge.
  - The edge where cnt==TIMEOUT-1 moves to HOLD, loads cnt=0, and sets WD_BITE.
- HOLD:
  - All four reset outputs are low.
  - The edge where cnt==HOLD_LEN-1 moves to REL_YM with cnt=0.
- REL_YM:
  - nYMRST is high; nZ80RST, nRESET and nHALT stay low.
  - After REL_LAG edges, moves to REL_Z80.
- REL_Z80:
  - nYMRST and nZ80RST are high; nRESET and nHALT stay low.
  - After REL_LAG edges, moves to RUN with cnt=0.
- RUN outputs: nRESET=nHALT=nZ80RST=nYMRST=1, each gated by nRST.
- WD_WARN is high only in RUN with cnt ≥ TIMEOUT-WARN_LEAD. It is registered, changing on WDCLK edges.
- WD_BITE is high from the bite edge until the next edge. It is then cleared unconditionally.
- nRST low:
  - All reset outputs go low combinationally.
  - On each edge while nRST is low: state←HOLD and cnt←HOLD_LEN-1. After nRST rises, the first edge goes to REL_YM, so power-on release follows the same staging.
- WDRESET high (asynchronous): state←RUN, cnt←0, WD_BITE←0, WD_WARN←0. This applies in any state, including HOLD and REL_*, where the strobe aborts the sequence and releases all lines immediately (still gated by nRST).
- WDRESET and nRST both active: WDRESET sets the flops, and nRST still forces the outputs low.
- cnt width is clog2(max(TIMEOUT, HOLD_LEN, REL_LAG)) bits, unsigned, and never wraps: every terminal value causes a state change.

## Timing
- Bite latency: TIMEOUT edges after WDRESET falls (default: the 8th edge).
- Edge numbering for defaults, with edge T the bite:
  - T: HOLD.
  - T+8: nYMRST rises.
  - T+10: nZ80RST rises.
  - T+12: nRESET/nHALT rise, RUN cnt=0.
- Next bite with no kick: T+12+TIMEOUT.
- Reset values (WDRESET): WD_STATE=0, WD_BITE=0, WD_WARN=0. All resets are high when nRST=1, all low when nRST=0.
- WDRESET assert-to-output: combinational through the flop clear. Its release must meet WDCLK recovery time; upstream synchronizes WDRESET deassertion.

## Structure
- Package wd_pkg holds:
  - the one-hot state typedef and the 2-bit WD_STATE codes;
  - the default values of TIMEOUT, HOLD_LEN, REL_LAG and WARN_LEAD;
  - a clog2 helper.
- One sub-module, wd_phase_counter: a loadable up-counter with async clear, sync load and a terminal-compare output. It is shared across all phases, with the terminal value muxed by state.

## Test plan
- Kick, then 7 edges with no kick: WD_BITE=0, WD_WARN high on edges 6–7, state RUN. On the 8th edge: WD_BITE=1, state HOLD, all resets low.
- Full sequence after a bite: nYMRST rises at T+8, nZ80RST at T+10, nRESET/nHALT at T+12. WD_BITE is low from T+1.
- Kick every 5 edges for 100 edges: no bite, WD_WARN never high, outputs constant high.
- WDRESET pulse mid-HOLD (edge T+3): all resets high immediately, WD_STATE=0, cnt=0. The next bite comes 8 edges later.
- nRST low for 20 edges, then high:
  - outputs low throughout;
  - first edge after release gives nYMRST=1;
  - 2 edges later nZ80RST=1;
  - 4 edges later nRESET=1.
- WDRESET asserted together with nRST low: outputs stay low while nRST is low. When nRST goes high with WDRESET having set RUN, all outputs go high at once.

Source files
------------

// File: rtl/wd_pkg.sv
// Shared types, default timings and sizing helpers for the watchdog reset sequencer.
package wd_pkg;

  typedef enum logic [3:0] {
    ST_RUN     = 4'b0001,
    ST_HOLD    = 4'b0010,
    ST_REL_YM  = 4'b0100,
    ST_REL_Z80 = 4'b1000
  } wd_state_e;

  localparam logic [1:0] CODE_RUN     = 2'd0;
  localparam logic [1:0] CODE_HOLD    = 2'd1;
  localparam logic [1:0] CODE_REL_YM  = 2'd2;
  localparam logic [1:0] CODE_REL_Z80 = 2'd3;

  localparam int WD_TIMEOUT_DEF   = 8;
  localparam int WD_HOLD_LEN_DEF  = 8;
  localparam int WD_REL_LAG_DEF   = 2;
  localparam int WD_WARN_LEAD_DEF = 2;

  // Bits needed to hold 0..v-1; never less than one bit.
  function automatic int wd_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int wd_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [1:0] wd_code(input wd_state_e s);
    logic [1:0] c;
    c = CODE_RUN;
    case (s)
      ST_HOLD:    c = CODE_HOLD;
      ST_REL_YM:  c = CODE_REL_YM;
      ST_REL_Z80: c = CODE_REL_Z80;
      default:    c = CODE_RUN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wd_phase_counter.sv
// Shared phase counter: async clear, synchronous load, otherwise counts up every edge.
// tc_o flags the current count equal to the terminal value chosen by the owner.
module wd_phase_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // No wrap protection needed: every phase leaves on its terminal count.
  assign cnt_d = load_i ? load_val_i : cnt_q + W'(1);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/wd_reset_sequencer.sv
// Watchdog timeout counter and staged system reset release (YM, then Z80, then 68k/HALT).
// The kick strobe WDRESET is the async clear, so a kick returns everything to RUN instantly.
module wd_reset_sequencer
  import wd_pkg::*;
#(
  parameter int TIMEOUT   = WD_TIMEOUT_DEF,
  parameter int HOLD_LEN  = WD_HOLD_LEN_DEF,
  parameter int REL_LAG   = WD_REL_LAG_DEF,
  parameter int WARN_LEAD = WD_WARN_LEAD_DEF
) (
  input  logic       WDCLK,
  input  logic       WDRESET,
  input  logic       nRST,
  output logic       nRESET,
  output logic       nHALT,
  output logic       nZ80RST,
  output logic       nYMRST,
  output logic       WD_BITE,
  output logic       WD_WARN,
  output logic [1:0] WD_STATE
);

  localparam int CNT_W   = wd_clog2(wd_max3(TIMEOUT, HOLD_LEN, REL_LAG));
  localparam int WARN_AT = TIMEOUT - WARN_LEAD;

  localparam logic [CNT_W-1:0] T_RUN  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] T_HOLD = CNT_W'(HOLD_LEN - 1);
  localparam logic [CNT_W-1:0] T_REL  = CNT_W'(REL_LAG - 1);

  wd_state_e        state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  logic       bite_q, bite_d;
  logic       warn_q, warn_d;
  logic       ym_q, ym_d;
  logic       z80_q, z80_d;
  logic       cpu_q, cpu_d;
  logic [1:0] code_q, code_d;

  wd_phase_counter #(.W(CNT_W)) u_cnt (
    .clk_i      (WDCLK),
    .arst_i     (WDRESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .term_i     (cnt_term),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_term     = T_RUN;
    bite_d       = 1'b0;
    warn_d       = 1'b0;

    if (!nRST) begin
      // Park one edge short of the end of HOLD so power-on release uses the normal staging.
      state_d      = ST_HOLD;
      cnt_load     = 1'b1;
      cnt_load_val = T_HOLD;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          cnt_term = T_RUN;
          if (cnt_tc) begin
            state_d  = ST_HOLD;
            cnt_load = 1'b1;
            bite_d   = 1'b1;
          end else begin
            warn_d = ((int'(cnt) + 1) >= WARN_AT);
          end
        end
        ST_HOLD: begin
          cnt_term = T_HOLD;
          if (cnt_tc) begin
            state_d  = ST_REL_YM;
            cnt_load = 1'b1;
          end
        end
        ST_REL_YM: begin
          cnt_term = T_REL;
          if (cnt_tc) begin
            state_d  = ST_REL_Z80;
            cnt_load = 1'b1;
          end
        end
        ST_REL_Z80: begin
          cnt_term = T_REL;
          if (cnt_tc) begin
            state_d  = ST_RUN;
            cnt_load = 1'b1;
          end
        end
        default: begin
          state_d      = ST_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = T_HOLD;
        end
      endcase
    end

    // Outputs are registered from the next state so each pin is a bare flop.
    ym_d   = (state_d != ST_HOLD);
    z80_d  = (state_d == ST_RUN) || (state_d == ST_REL_Z80);
    cpu_d  = (state_d == ST_RUN);
    code_d = wd_code(state_d);
  end

  always_ff @(posedge WDCLK or posedge WDRESET) begin
    if (WDRESET) begin
      state_q <= ST_RUN;
      bite_q  <= 1'b0;
      warn_q  <= 1'b0;
      ym_q    <= 1'b1;
      z80_q   <= 1'b1;
      cpu_q   <= 1'b1;
      code_q  <= CODE_RUN;
    end else begin
      state_q <= state_d;
      bite_q  <= bite_d;
      warn_q  <= warn_d;
      ym_q    <= ym_d;
      z80_q   <= z80_d;
      cpu_q   <= cpu_d;
      code_q  <= code_d;
    end
  end

  assign nYMRST   = ym_q  & nRST;
  assign nZ80RST  = z80_q & nRST;
  assign nRESET   = cpu_q & nRST;
  assign nHALT    = cpu_q & nRST;
  assign WD_BITE  = bite_q;
  assign WD_WARN  = warn_q;
  assign WD_STATE = code_q;

endmodule

// File: tb/tb_wd_reset_sequencer.sv
// Bench for wd_reset_sequencer: directed scenarios then random kicks/nRST against a timeline model.
module tb_wd_reset_sequencer;

  localparam int TIMEOUT   = 8;
  localparam int HOLD_LEN  = 8;
  localparam int REL_LAG   = 2;
  localparam int WARN_LEAD = 2;

  logic       WDCLK = 1'b0;
  logic       WDRESET = 1'b0;
  logic       nRST = 1'b1;
  logic       nRESET, nHALT, nZ80RST, nYMRST, WD_BITE, WD_WARN;
  logic [1:0] WD_STATE;

  int n_vec = 0;
  int n_err = 0;

  // Model: in_seq says a timeout sequence is in progress; e counts edges since entering RUN
  // (when !in_seq) or since the bite edge (when in_seq).
  bit m_in_seq = 1'b0;
  int m_e = 0;
  bit m_bite = 1'b0;

  wd_reset_sequencer #(
    .TIMEOUT(TIMEOUT), .HOLD_LEN(HOLD_LEN), .REL_LAG(REL_LAG), .WARN_LEAD(WARN_LEAD)
  ) dut (
    .WDCLK(WDCLK), .WDRESET(WDRESET), .nRST(nRST),
    .nRESET(nRESET), .nHALT(nHALT), .nZ80RST(nZ80RST), .nYMRST(nYMRST),
    .WD_BITE(WD_BITE), .WD_WARN(WD_WARN), .WD_STATE(WD_STATE)
  );

  always #5 WDCLK = ~WDCLK;

  function automatic logic [7:0] observed();
    return {WD_STATE, nYMRST, nZ80RST, nRESET, nHALT, WD_BITE, WD_WARN};
  endfunction

  function automatic logic [7:0] expected();
    logic [1:0] code;
    logic ym, z80, cpu, warn;
    if (!m_in_seq) begin
      code = 2'd0; ym = 1'b1; z80 = 1'b1; cpu = 1'b1;
      warn = (m_e >= TIMEOUT - WARN_LEAD);
    end else begin
      warn = 1'b0;
      cpu  = 1'b0;
      ym   = (m_e >= HOLD_LEN);
      z80  = (m_e >= HOLD_LEN + REL_LAG);
      if (m_e < HOLD_LEN)                code = 2'd1;
      else if (m_e < HOLD_LEN + REL_LAG) code = 2'd2;
      else                               code = 2'd3;
    end
    return {code, ym & nRST, z80 & nRST, cpu & nRST, cpu & nRST, m_bite, warn};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b (state,ym,z80,rst,halt,bite,warn)", tag, obs, exp);
    end
  endtask

  task automatic model_kick();
    m_in_seq = 1'b0;
    m_e = 0;
    m_bite = 1'b0;
  endtask

  task automatic model_edge();
    m_bite = 1'b0;
    if (WDRESET) begin
      model_kick();
    end else if (!nRST) begin
      m_in_seq = 1'b1;
      m_e = HOLD_LEN - 1;
    end else if (!m_in_seq) begin
      m_e++;
      if (m_e == TIMEOUT) begin
        m_in_seq = 1'b1;
        m_e = 0;
        m_bite = 1'b1;
      end
    end else begin
      m_e++;
      if (m_e == HOLD_LEN + 2 * REL_LAG) begin
        m_in_seq = 1'b0;
        m_e = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge WDCLK);
    model_edge();
    #1;
    chk(tag, observed(), expected());
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic kick(input string tag);
    WDRESET = 1'b1;
    #1;
    model_kick();
    chk(tag, observed(), expected());
    WDRESET = 1'b0;
    #1;
  endtask

  initial begin
    // Hold the kick strobe across a couple of edges to reach a defined state.
    #1 WDRESET = 1'b1;
    @(posedge WDCLK);
    @(posedge WDCLK);
    #1;
    chk("reset_state", observed(), 8'b00_1111_00);
    WDRESET = 1'b0;
    model_kick();

    // Timeout: seven quiet edges then the bite on the eighth.
    ticks(7, "pre_bite");
    tick("bite_edge");
    chk("bite_const", observed(), 8'b01_0000_10);

    // Staged release back to RUN, then part of the next countdown.
    ticks(8, "hold_to_ym");
    chk("ym_release", observed(), 8'b10_1000_00);
    ticks(2, "ym_to_z80");
    chk("z80_release", observed(), 8'b11_1100_00);
    ticks(2, "z80_to_run");
    chk("cpu_release", observed(), 8'b00_1111_00);
    ticks(8, "second_bite");
    chk("second_bite_const", observed(), 8'b01_0000_10);

    // Regular kicks every 5 edges keep the sequencer quiet.
    kick("kick_start");
    for (int k = 0; k < 20; k++) begin
      ticks(5, "kick_every_5");
      kick("kick_every_5_pulse");
    end

    // Kick in the middle of HOLD aborts the sequence at once.
    ticks(8, "to_bite");
    ticks(3, "into_hold");
    kick("kick_mid_hold");
    chk("kick_mid_hold_const", observed(), 8'b00_1111_00);
    ticks(8, "rebite_after_abort");

    // Power-on reset held for 20 edges, then released through the staging.
    nRST = 1'b0;
    #1 chk("nrst_fall_comb", observed(), expected());
    ticks(20, "nrst_low");
    nRST = 1'b1;
    #1 chk("nrst_rise_comb", observed(), expected());
    tick("nrst_first_edge");
    chk("nrst_ym_const", observed(), 8'b10_1000_00);
    ticks(2, "nrst_z80");
    ticks(2, "nrst_cpu");
    chk("nrst_cpu_const", observed(), 8'b00_1111_00);

    // Kick held while nRST is low: lines stay low, then all rise together.
    nRST = 1'b0;
    ticks(3, "both_nrst_only");
    WDRESET = 1'b1;
    #1;
    model_kick();
    chk("both_active", observed(), 8'b00_0000_00);
    ticks(3, "both_held");
    nRST = 1'b1;
    #1 chk("both_nrst_rise", observed(), 8'b00_1111_00);
    WDRESET = 1'b0;
    #1;

    // Random kicks and nRST activity.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) kick("rand_kick");
      if ($urandom_range(0, 19) == 0) begin
        nRST = ~nRST;
        #1 chk("rand_nrst_comb", observed(), expected());
      end
      tick("rand_edge");
    end
    nRST = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
